// File: rtl/add_sched.sv
// Round-robin scheduler sharing one W-bit adder among N requesters.
// Define ADD_SCHED_PIPE_EN for a two-stage (operand register + adder) variant.
module add_sched #(
  parameter int N = 4,
  parameter int W = 64,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  output logic [N-1:0]    req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_sum,
  output logic            rsp_cout,
  output logic [IW-1:0]   rsp_id,
  output logic [15:0]     ops_cnt
);

  logic [W-1:0]  a_arr [N];
  logic [W-1:0]  b_arr [N];
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] win;
  logic [IW:0]   idx_wide;
  logic          win_found;
  logic          issue_ok;
  logic          grant;
  logic          out_adv;
  logic [W-1:0]  a_sel, b_sel;
  logic [W:0]    sum_full;
  logic [15:0]   cnt_reg;
  logic          rsp_valid_reg;
  logic [W-1:0]  rsp_sum_reg;
  logic          rsp_cout_reg;
  logic [IW-1:0] rsp_id_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*W +: W];
      assign b_arr[gi] = req_b[gi*W +: W];
    end
  endgenerate

  // First valid requester at or after ptr, wrapping modulo N.
  always_comb begin
    win       = ptr_reg;
    win_found = 1'b0;
    idx_wide  = '0;
    for (int k = 0; k < N; k++) begin
      idx_wide = {1'b0, ptr_reg} + (IW+1)'(k);
      if (idx_wide >= (IW+1)'(N))
        idx_wide = idx_wide - (IW+1)'(N);
      if (!win_found && req_valid[idx_wide[IW-1:0]]) begin
        win_found = 1'b1;
        win       = idx_wide[IW-1:0];
      end
    end
  end

  assign out_adv   = !rsp_valid_reg || rsp_ready;
  assign grant     = win_found && issue_ok && !rst;
  assign req_ready = grant ? (N'(1) << win) : '0;
  assign a_sel     = a_arr[win];
  assign b_sel     = b_arr[win];
  assign ptr_next  = (win == IW'(N-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else if (grant) begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

`ifdef ADD_SCHED_PIPE_EN
  logic          s1_valid_reg;
  logic [W-1:0]  s1_a_reg, s1_b_reg;
  logic [IW-1:0] s1_id_reg;

  // Stage 1 may refill while its content moves into the output register.
  assign issue_ok = !s1_valid_reg || out_adv;
  assign sum_full = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_id_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_sum_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      if (issue_ok) begin
        s1_valid_reg <= grant;
        if (grant) begin
          s1_a_reg  <= a_sel;
          s1_b_reg  <= b_sel;
          s1_id_reg <= win;
        end
      end
      if (out_adv) begin
        rsp_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          rsp_sum_reg  <= sum_full[W-1:0];
          rsp_cout_reg <= sum_full[W];
          rsp_id_reg   <= s1_id_reg;
        end
      end
    end
  end
`else
  assign issue_ok = out_adv;
  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_sum_reg   <= '0;
      rsp_cout_reg  <= 1'b0;
      rsp_id_reg    <= '0;
    end else if (grant) begin
      rsp_valid_reg <= 1'b1;
      rsp_sum_reg   <= sum_full[W-1:0];
      rsp_cout_reg  <= sum_full[W];
      rsp_id_reg    <= win;
    end else if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end
`endif

  assign rsp_valid = rsp_valid_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_id    = rsp_id_reg;
  assign ops_cnt   = cnt_reg;

endmodule

// File: tb/tb_add_sched.sv
// Randomized and directed bench for add_sched with a queue-based reference model.
module tb_add_sched;
  localparam int N = 4;
  localparam int W = 64;
`ifdef ADD_SCHED_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [W:0] s;
    int         id;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [1:0]     rsp_id;
  logic [15:0]    ops_cnt;

  add_sched #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  exp_t        q[$];
  int          m_ptr    = 0;
  logic [15:0] m_cnt    = '0;
  bit          in_reset = 1'b0;

  logic [N-1:0] s_ready;
  logic         s_rsp_valid;
  logic [W-1:0] s_sum;
  logic         s_cout;
  logic [1:0]   s_id;
  logic [15:0]  s_ops;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, check against the model, advance the model.
  task automatic tick();
    int   w;
    int   in_s1;
    bit   exp_grant;
    exp_t e;
    @(negedge clk);
    s_ready = req_ready; s_rsp_valid = rsp_valid; s_sum = rsp_sum;
    s_cout = rsp_cout; s_id = rsp_id; s_ops = ops_cnt;
    if (rst) begin
      chk("ready_in_reset", 128'(req_ready), 128'(0));
      q.delete();
      m_ptr = 0;
      m_cnt = '0;
      in_reset = 1'b1;
    end else begin
      if (in_reset) begin
        chk("post_reset_valid", 128'(rsp_valid), 128'(0));
        chk("post_reset_ops", 128'(ops_cnt), 128'(0));
        chk("post_reset_sum", 128'({rsp_cout, rsp_sum}), 128'(0));
        chk("post_reset_id", 128'(rsp_id), 128'(0));
      end
      in_reset = 1'b0;
      chk("ops_cnt", 128'(ops_cnt), 128'(m_cnt));
      chk("ready_subset", 128'(req_ready & ~req_valid), 128'(0));
      chk("ready_onehot", 128'($countones(req_ready) > 1), 128'(0));
      chk("rsp_without_pending", 128'(rsp_valid && q.size() == 0), 128'(0));
      in_s1 = q.size() - (rsp_valid ? 1 : 0);
      exp_grant = (req_valid != 0) && !(rsp_valid && !rsp_ready && in_s1 >= LAT - 1);
      chk("grant_expected", 128'(req_ready != 0), 128'(exp_grant));
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (req_ready != 0)
        chk("rr_winner", 128'(req_ready), 128'(1) << w);
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_sum_cout", 128'({rsp_cout, rsp_sum}), 128'(e.s));
        chk("rsp_id", 128'(rsp_id), 128'(e.id));
      end
      if ((req_valid & req_ready) != 0 && w >= 0) begin
        e.s  = {1'b0, req_a[w*W +: W]} + {1'b0, req_b[w*W +: W]};
        e.id = w;
        q.push_back(e);
        m_ptr = (w + 1) % N;
        m_cnt = m_cnt + 16'd1;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((q.size() > 0 || rsp_valid) && g < 20) begin
      tick();
      g++;
    end
    chk("drain_empty", 128'(q.size()), 128'(0));
  endtask

  task automatic wait_rsp(input string tag);
    int g = 0;
    do begin
      tick();
      g++;
    end while (!s_rsp_valid && g < 10);
    chk(tag, 128'(s_rsp_valid), 128'(1));
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = {$urandom, $urandom};
      req_b[i*W +: W] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int g;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Single operation, accepted in the first cycle after reset release.
    req_valid = 4'b0001;
    req_a[0 +: W] = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b[0 +: W] = 64'd1;
    tick();
    chk("first_after_reset", 128'(s_ready), 128'(4'b0001));
    req_valid = '0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_rsp_valid && lat < 10);
    chk("single_latency", 128'(lat), 128'(LAT));
    chk("single_sum", 128'(s_sum), 128'(0));
    chk("single_cout", 128'(s_cout), 128'(1));
    chk("single_id", 128'(s_id), 128'(0));
    drain();

    // Fairness with all requesters valid.
    rst = 1'b1; tick(); rst = 1'b0;
    rand_ops();
    req_valid = 4'hF; rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("fair_grant", 128'(s_ready), 128'(1) << (k % 4));
      chk("fair_ops", 128'(s_ops), 128'(k));
    end
    drain();

    // Backpressure: result 3+5 held while the consumer stalls.
    req_a[1*W +: W] = 64'd3; req_b[1*W +: W] = 64'd5;
    req_valid = 4'b0010; rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    wait_rsp("bp_result");
    req_valid = 4'hF;
    base = n_acc;
    repeat (5) begin
      tick();
      chk("bp_valid", 128'(s_rsp_valid), 128'(1));
      chk("bp_sum", 128'({s_cout, s_sum}), 128'(8));
    end
    chk("bp_accepts", 128'(n_acc - base), 128'(LAT - 1));
    chk("bp_ready", 128'(s_ready), 128'(0));
    drain();

    // Drain and accept in the same cycle.
    rand_ops();
    req_valid = 4'b0001; rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    wait_rsp("da_first");
    req_valid = 4'b0100; rsp_ready = 1'b1;
    tick();
    chk("da_ready", 128'(s_ready), 128'(4'b0100));
    req_valid = '0; rsp_ready = 1'b0;
    repeat (LAT) tick();
    chk("da_valid", 128'(s_rsp_valid), 128'(1));
    chk("da_id", 128'(s_id), 128'(2));
    drain();

    // Reset with results pending.
    rand_ops();
    req_valid = 4'b0110; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    req_valid = 4'hF; rsp_ready = 1'b1;
    tick();
    chk("rst_valid", 128'(s_rsp_valid), 128'(0));
    chk("rst_ops", 128'(s_ops), 128'(0));
    chk("rst_next_grant", 128'(s_ready), 128'(4'b0001));
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      req_valid = N'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end
    drain();

    // Counter wrap.
    req_valid = 4'hF; rsp_ready = 1'b1;
    g = 0;
    while (m_cnt != 16'hFFFF && g < 70000) begin
      tick();
      g++;
    end
    tick();
    chk("wrap_pre", 128'(s_ops), 128'(16'hFFFF));
    req_valid = '0;
    tick();
    chk("wrap_post", 128'(s_ops), 128'(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sched.md
ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters sharing the adder (2..8).
REQ-002 SHALL have parameter W, default 64, operand width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  N  per-requester operand-pair valid.
REQ-006 SHALL have port req_a  input  N*W  operand A; requester i occupies bits [i*W +: W].
REQ-007 SHALL have port req_b  input  N*W  operand B; same packing as req_a.
REQ-008 SHALL have port req_ready  output  N  one-hot-or-zero grant; transfer when req_valid[i] & req_ready[i].
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_sum  output  W  sum bits.
REQ-012 SHALL have port rsp_cout  output  1  carry out of bit W-1.
REQ-013 SHALL have port rsp_id  output  clog2(N)  index of the requester that produced the result.
REQ-014 SHALL have port ops_cnt  output  16  count of accepted operations.

Function
REQ-015 SHALL compute {rsp_cout, rsp_sum} = req_a[i] + req_b[i] with no carry-in, full W+1-bit result.
REQ-016 SHALL arbitrate round-robin: search starts at pointer ptr, first i with req_valid[i] set wins.
REQ-017 SHALL set ptr to (winner+1) mod N on each accepted transfer; ptr unchanged when nothing is accepted.
REQ-018 SHALL assert at most one req_ready bit, and only for a requester with req_valid high (ready may depend combinationally on valid).
REQ-019 SHALL grant only when the issue stage can advance: output register empty, or rsp_valid & rsp_ready in the same cycle.
REQ-020 SHALL, with the pipeline flag (REQ-033) off, load result, id and rsp_valid=1 at the edge of acceptance; result visible the following cycle (latency 1).
REQ-021 SHALL hold rsp_sum, rsp_cout and rsp_id stable while rsp_valid & !rsp_ready.
REQ-022 SHALL clear rsp_valid on rsp_valid & rsp_ready unless a new result loads that same edge.
REQ-023 SHALL sustain one accepted operation per cycle with rsp_ready held high.
REQ-024 SHALL increment ops_cnt by 1 per accepted transfer, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL let a requester deassert req_valid without being granted; no state change results.
REQ-026 SHALL drop no results and duplicate none; results leave in acceptance order.

Reset
REQ-027 SHALL, while rst is high, force rsp_valid=0, req_ready=0, ptr=0 and ops_cnt=0.
REQ-028 SHALL reset rsp_sum, rsp_cout and rsp_id to 0.
REQ-029 SHALL discard in-flight operations when rst asserts mid-operation; no result appears after release.
REQ-030 SHALL accept requests starting from the first cycle after rst deasserts.

Configuration
REQ-031 SHALL support macro ADD_SCHED_PIPE_EN.
REQ-032 SHALL, when the macro is undefined, implement the single-stage behaviour of REQ-020.
REQ-033 SHALL, when the macro is defined, register operands and id in a stage-1 register, add in stage 2, latency 2.
REQ-034 SHALL, with the macro defined, stall stage 1 only when it is full and stage 2 cannot advance; throughput stays 1 per cycle.

Verification
REQ-035 SHALL test a single operation: req 0, a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> rsp_sum=0, rsp_cout=1, rsp_id=0, latency 1 (2 with macro).
REQ-036 SHALL test fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,…; ops_cnt increments by 1 per cycle.
REQ-037 SHALL test backpressure: rsp_ready=0 for 5 cycles after one result (a=3, b=5) -> sum 8 held stable, req_ready=0, no new accepts.
REQ-038 SHALL test simultaneous drain and accept: rsp_valid=1, rsp_ready=1, req 2 valid -> same-cycle accept, rsp_valid stays 1 with id 2.
REQ-039 SHALL test reset mid-stream: rst pulsed with results pending -> rsp_valid=0, ops_cnt=0, next grant goes to requester 0.
REQ-040 SHALL test counter wrap: preload ops_cnt to 0xFFFF via 65535 accepts, one more accept -> 0x0000.
